capture_ctrl: RTL and testbench
===============================

# capture_ctrl

Capture sequencer for the logic-capture path. It turns host arm/abort commands, the trigger unit's hit signal and the sample generator's completion strobe into the phase controls the sample generator consumes: idle, start, preTrigger, postTrigger, triggered and abort. It enforces the pre-trigger fill requirement before a trigger is accepted. It also holds the finished-capture state until the host acknowledges readback.

## Interface
- PRETRIG_CNT_WIDTH, 32: width of the fill counter and of pretrig_count_max.
- TIMEOUT_WIDTH, 32: width of the trigger-timeout counter (used only with the timeout feature).
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_arm  in  1  one-cycle host pulse; starts a capture.
- cmd_abort  in  1  one-cycle host pulse; ends the capture early.
- cmd_ack  in  1  one-cycle host pulse; readback finished, release DONE.
- trig_hit  in  1  trigger unit match, level or pulse.
- sample_we  in  1  sample generator write_enable; one per stored packet.
- complete  in  1  sample generator completion strobe.
- pretrig_count_max  in  PRETRIG_CNT_WIDTH  packets to store before the trigger is unmasked.
- trig_timeout  in  TIMEOUT_WIDTH  ARMED-cycle limit; port present only when CAPTURE_TRIG_TIMEOUT_EN is defined.
- idle  out  1  high in IDLE.
- start  out  1  one-cycle pulse in START.
- pre_trigger  out  1  high in FILL, ARMED, and ABORT-from-pre.
- post_trigger  out  1  high in POST and ABORT-from-post.
- triggered  out  1  qualified trigger, combinational.
- abort  out  1  high only in ABORT.
- capture_valid  out  1  high in DONE.
- status  out  4  bits [2:0] are the state code; bit 3 is forced_trig.

## Operation
- The FSM state is a registered 3-bit code with these values: IDLE=0, START=1, FILL=2, ARMED=3, POST=4, DONE=5, ABORT=6.
- **IDLE**
  - cmd_arm moves to START.
  - All other inputs are ignored.
- **START**
  - Lasts exactly one cycle.
  - Clears fill_cnt, the timeout counter and forced_trig.
  - Goes to ARMED if pretrig_count_max==0, otherwise to FILL.
- **FILL**
  - fill_cnt increments on each sample_we.
  - When fill_cnt+sample_we == pretrig_count_max, go to ARMED.
  - trig_hit is masked in this state.
- **ARMED**
  - triggered = trig_hit; when it is high, go to POST.
- **POST**
  - complete goes to DONE.
- **DONE**
  - cmd_ack goes to IDLE.
  - cmd_arm goes to START; arm wins over ack.
  - The status contents are preserved while in DONE.
- **Abort**
  - cmd_abort in FILL, ARMED or POST goes to ABORT.
  - ABORT lasts one cycle with abort=1.
  - In ABORT, pre_trigger or post_trigger stays at the value from the aborted phase, so the sample generator latches its end numbers.
  - ABORT then moves to DONE.
  - cmd_abort in IDLE, START or DONE is ignored.
- **Priority within a cycle:** cmd_abort > complete > trig_hit > fill/timeout transitions.
  - trig_hit together with cmd_abort in ARMED: triggered=0, go to ABORT.
- The fill counter saturates at all-ones and never wraps.
- pretrig_count_max is sampled every cycle and must be held stable by the host during a capture.

## Timing
- **Reset values:** state=IDLE, idle=1, start=0, pre_trigger=0, post_trigger=0, triggered=0, abort=0, capture_valid=0, status=4'h0, all counters 0.
- **Command latency:** cmd_arm to start is 1 cycle; cmd_arm to pre_trigger is 2 cycles.
- **Trigger timing:** triggered is asserted in the same cycle as trig_hit. post_trigger rises on the next cycle and pre_trigger falls on that cycle.
- **Completion:** complete in POST makes capture_valid high on the next cycle.
- **Abort:** cmd_abort makes abort high on the next cycle and capture_valid high 2 cycles after cmd_abort.
- **Outputs:** all outputs except triggered are decoded from the registered state; they are glitch-free and change only on clk edges.
- **Reset during a capture:** reset_n low at any point drops immediately to the reset values with no abort pulse. The sample generator is reset by the same net.

## Configuration
- **CAPTURE_TRIG_TIMEOUT_EN defined:**
  - A counter runs while in ARMED.
  - When it reaches trig_timeout (with trig_timeout nonzero), triggered is forced high for one cycle, forced_trig=1 and the FSM goes to POST.
  - trig_timeout==0 disables the timeout.
- **Not defined:**
  - The counter and the trig_timeout port are removed.
  - The FSM waits in ARMED indefinitely.
  - status[3] is tied to 0.

## Structure
- **Shared package capture_pkg:**
  - The state encoding localparams (IDLE..ABORT).
  - The STATUS_WIDTH constant.
  - The status bit positions.
- **Sub-module capture_timeout_ctr:**
  - Contents: a loadable cycle counter with an expiry strobe.
  - Instantiated only under CAPTURE_TRIG_TIMEOUT_EN.
- FSM and output decode stay in capture_ctrl.

## Test plan
- **Basic capture:** reset, then pretrig_count_max=4, cmd_arm, 4 sample_we pulses, then trig_hit.
  - start is high one cycle after arm.
  - ARMED after the 4th write.
  - triggered is high for 1 cycle.
  - POST follows; complete leads to DONE with status=5; cmd_ack leads to IDLE.
- **Trigger masking:** pretrig_count_max=3, trig_hit held high from arm.
  - triggered stays 0 until ARMED.
  - Then triggered=1 for exactly one cycle and POST is entered.
- **Abort in POST:** cmd_abort during POST.
  - abort=1 and post_trigger=1 in the same cycle.
  - Next cycle: DONE with capture_valid=1.
- **Simultaneous abort and trigger:** trig_hit and cmd_abort together in ARMED.
  - triggered=0, then ABORT with pre_trigger=1, then DONE.
- **Zero pre-trigger and re-arm:** pretrig_count_max=0.
  - START goes directly to ARMED.
  - In DONE, cmd_arm and cmd_ack together lead to START.
- **Timeout (macro on) and reset mid-capture:**
  - trig_timeout=10 with no trig_hit: triggered is forced 10 cycles after entering ARMED, status[3]=1.
  - reset_n low in POST returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared encodings and status layout for the capture sequencer.
package capture_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_ARMED = 3'd3;
    localparam logic [2:0] ST_POST  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ABORT = 3'd6;

    localparam int STATUS_WIDTH      = 4;
    localparam int STATUS_STATE_LSB  = 0;
    localparam int STATUS_STATE_MSB  = 2;
    localparam int STATUS_FORCED_BIT = 3;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_FILL  = ST_FILL,
        S_ARMED = ST_ARMED,
        S_POST  = ST_POST,
        S_DONE  = ST_DONE,
        S_ABORT = ST_ABORT
    } state_e;

endpackage

// File: rtl/capture_ctrl_if.sv
// Command/trigger/phase bundle between host side and the sequencer.
// trig_timeout exists only when CAPTURE_TRIG_TIMEOUT_EN is defined.
interface capture_ctrl_if #(
    parameter int PRETRIG_CNT_WIDTH = 32,
    parameter int TIMEOUT_WIDTH     = 32
);
    import capture_pkg::*;

    logic                         cmd_arm;
    logic                         cmd_abort;
    logic                         cmd_ack;
    logic                         trig_hit;
    logic                         sample_we;
    logic                         complete;
    logic [PRETRIG_CNT_WIDTH-1:0] pretrig_count_max;
`ifdef CAPTURE_TRIG_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0]     trig_timeout;
`endif
    logic                         idle;
    logic                         start;
    logic                         pre_trigger;
    logic                         post_trigger;
    logic                         triggered;
    logic                         abort;
    logic                         capture_valid;
    logic [STATUS_WIDTH-1:0]      status;

    modport master (
        output cmd_arm, cmd_abort, cmd_ack,
        output trig_hit, sample_we, complete,
        output pretrig_count_max,
`ifdef CAPTURE_TRIG_TIMEOUT_EN
        output trig_timeout,
`endif
        input  idle, start, pre_trigger, post_trigger,
        input  triggered, abort, capture_valid, status
    );

    modport slave (
        input  cmd_arm, cmd_abort, cmd_ack,
        input  trig_hit, sample_we, complete,
        input  pretrig_count_max,
`ifdef CAPTURE_TRIG_TIMEOUT_EN
        input  trig_timeout,
`endif
        output idle, start, pre_trigger, post_trigger,
        output triggered, abort, capture_valid, status
    );

endinterface

// File: rtl/capture_timeout_ctr.sv
// Loadable cycle counter with expiry strobe for the ARMED timeout.
module capture_timeout_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear_i,
    input  logic         run_i,
    input  logic [W-1:0] limit_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (run_i && cnt_q != '1)
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // A zero limit means the timeout is disabled.
    assign expire_o = run_i && (limit_i != '0) && (cnt_q == limit_i);

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: phase FSM, pre-trigger fill gate, abort and readback hold.
// Optional trigger timeout enabled by defining CAPTURE_TRIG_TIMEOUT_EN.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int PRETRIG_CNT_WIDTH = 32,
    parameter int TIMEOUT_WIDTH     = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    capture_ctrl_if.slave  bus
);

    localparam int PW = PRETRIG_CNT_WIDTH;

    state_e        state_q, state_d;
    logic [PW-1:0] fill_q, fill_d;
    logic          forced_q, forced_d;
    logic          ab_post_q, ab_post_d;
    logic          trig;
    logic          tmo_expire;
    logic          fill_hit;

`ifdef CAPTURE_TRIG_TIMEOUT_EN
    capture_timeout_ctr #(.W(TIMEOUT_WIDTH)) u_tmo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (state_q == S_START),
        .run_i    (state_q == S_ARMED),
        .limit_i  (bus.trig_timeout),
        .expire_o (tmo_expire)
    );
`else
    assign tmo_expire = 1'b0;
`endif

    // Widened compare so a saturated counter can never alias to the target.
    assign fill_hit = ({1'b0, fill_q} + {{PW{1'b0}}, bus.sample_we})
                      == {1'b0, bus.pretrig_count_max};

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        forced_d  = forced_q;
        ab_post_d = ab_post_q;
        trig      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_arm)
                    state_d = S_START;
            end
            S_START: begin
                fill_d   = '0;
                forced_d = 1'b0;
                state_d  = (bus.pretrig_count_max == '0) ? S_ARMED : S_FILL;
            end
            S_FILL: begin
                if (bus.cmd_abort) begin
                    state_d   = S_ABORT;
                    ab_post_d = 1'b0;
                end else begin
                    if (bus.sample_we && fill_q != '1)
                        fill_d = fill_q + PW'(1);
                    if (fill_hit)
                        state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.cmd_abort) begin
                    state_d   = S_ABORT;
                    ab_post_d = 1'b0;
                end else if (bus.trig_hit) begin
                    trig    = 1'b1;
                    state_d = S_POST;
                end else if (tmo_expire) begin
                    trig     = 1'b1;
                    forced_d = 1'b1;
                    state_d  = S_POST;
                end
            end
            S_POST: begin
                if (bus.cmd_abort) begin
                    state_d   = S_ABORT;
                    ab_post_d = 1'b1;
                end else if (bus.complete) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.cmd_arm)
                    state_d = S_START;
                else if (bus.cmd_ack)
                    state_d = S_IDLE;
            end
            S_ABORT: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            fill_q    <= '0;
            forced_q  <= 1'b0;
            ab_post_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            forced_q  <= forced_d;
            ab_post_q <= ab_post_d;
        end
    end

    assign bus.idle          = (state_q == S_IDLE);
    assign bus.start         = (state_q == S_START);
    assign bus.pre_trigger   = (state_q == S_FILL) || (state_q == S_ARMED)
                               || (state_q == S_ABORT && !ab_post_q);
    assign bus.post_trigger  = (state_q == S_POST)
                               || (state_q == S_ABORT && ab_post_q);
    assign bus.triggered     = trig;
    assign bus.abort         = (state_q == S_ABORT);
    assign bus.capture_valid = (state_q == S_DONE);

    always_comb begin
        bus.status = '0;
        bus.status[STATUS_STATE_MSB:STATUS_STATE_LSB] = state_q;
        bus.status[STATUS_FORCED_BIT] = forced_q;
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized scenario bench for capture_ctrl; expected outputs come from
// phase/cycle arithmetic derived from the capture sequencing rules.
module tb_capture_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    capture_ctrl_if bus ();

    capture_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    localparam int P_IDLE = 0, P_START = 1, P_FILL = 2, P_ARMED = 3;
    localparam int P_POST = 4, P_DONE = 5, P_ABORT = 6;

    // Expected output vector for a phase:
    // {idle,start,pre,post,triggered,abort,valid,status[3:0]}
    function automatic logic [10:0] expv(int ph, bit post_side,
                                         bit forced, bit trg);
        logic [2:0] code;
        code = 3'(ph);
        return {ph == P_IDLE, ph == P_START,
                ph == P_FILL || ph == P_ARMED || (ph == P_ABORT && !post_side),
                ph == P_POST || (ph == P_ABORT && post_side),
                trg, ph == P_ABORT, ph == P_DONE, forced, code};
    endfunction

    function automatic logic [10:0] obs();
        return {bus.idle, bus.start, bus.pre_trigger, bus.post_trigger,
                bus.triggered, bus.abort, bus.capture_valid, bus.status};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.cmd_arm   = 1'b0;
        bus.cmd_abort = 1'b0;
        bus.cmd_ack   = 1'b0;
        bus.trig_hit  = 1'b0;
        bus.sample_we = 1'b0;
        bus.complete  = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        reset_n = 1'b0;
        clr();
        bus.pretrig_count_max = '0;
`ifdef CAPTURE_TRIG_TIMEOUT_EN
        bus.trig_timeout = '0;
`endif
        #2;
        e = expv(P_IDLE, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_async got=%b exp=%b", obs(), e);
        end
        bus.cmd_arm = 1'b1;
        tick();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_held got=%b exp=%b", obs(), e);
        end
        bus.cmd_arm = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    // Random write gaps and random trig_hit noise while filling.
    task automatic test_basic();
        logic [10:0] e;
        int n, gap, wt, pw;
        n = $urandom_range(1, 6);
        bus.pretrig_count_max = 32'(n);
        bus.cmd_arm = 1'b1;
        #1;
        e = expv(P_IDLE, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL basic_idle got=%b exp=%b", obs(), e);
        end
        tick();
        clr();
        #1;
        e = expv(P_START, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL basic_start got=%b exp=%b", obs(), e);
        end
        tick();
        for (int w = 0; w < n; w++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g <= gap; g++) begin
                bus.sample_we = (g == gap);
                bus.trig_hit  = 1'($urandom);
                #1;
                e = expv(P_FILL, 0, 0, 0);
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL basic_fill n=%0d w=%0d got=%b exp=%b",
                             n, w, obs(), e);
                end
                tick();
            end
        end
        clr();
        wt = $urandom_range(0, 3);
        for (int k = 0; k <= wt; k++) begin
            bus.trig_hit = (k == wt);
            #1;
            e = expv(P_ARMED, 0, 0, k == wt);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL basic_armed k=%0d got=%b exp=%b", k, obs(), e);
            end
            tick();
        end
        clr();
        pw = $urandom_range(0, 2);
        for (int k = 0; k <= pw; k++) begin
            bus.complete = (k == pw);
            #1;
            e = expv(P_POST, 0, 0, 0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL basic_post k=%0d got=%b exp=%b", k, obs(), e);
            end
            tick();
        end
        clr();
        for (int k = 0; k < 3; k++) begin
            bus.cmd_abort = 1'($urandom);
            bus.trig_hit  = 1'($urandom);
            bus.cmd_ack   = (k == 2);
            #1;
            e = expv(P_DONE, 0, 0, 0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL basic_done k=%0d got=%b exp=%b", k, obs(), e);
            end
            tick();
        end
        clr();
        #1;
        e = expv(P_IDLE, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL basic_ack got=%b exp=%b", obs(), e);
        end
        tick();
    endtask

    task automatic test_masking();
        logic [10:0] e;
        bus.pretrig_count_max = 32'd3;
        bus.trig_hit = 1'b1;
        bus.cmd_arm  = 1'b1;
        tick();
        bus.cmd_arm = 1'b0;
        #1;
        e = expv(P_START, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL mask_start got=%b exp=%b", obs(), e);
        end
        tick();
        for (int w = 0; w < 3; w++) begin
            bus.sample_we = 1'b1;
            #1;
            e = expv(P_FILL, 0, 0, 0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL mask_fill w=%0d got=%b exp=%b", w, obs(), e);
            end
            tick();
        end
        bus.sample_we = 1'b0;
        #1;
        e = expv(P_ARMED, 0, 0, 1);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL mask_armed got=%b exp=%b", obs(), e);
        end
        tick();
        bus.complete = 1'b1;
        #1;
        e = expv(P_POST, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL mask_post got=%b exp=%b", obs(), e);
        end
        tick();
        clr();
        bus.cmd_ack = 1'b1;
        tick();
        clr();
    endtask

    task automatic test_abort_post();
        logic [10:0] e;
        bus.pretrig_count_max = '0;
        bus.cmd_arm = 1'b1;
        tick();
        clr();
        tick();
        bus.trig_hit = 1'b1;
        tick();
        clr();
        bus.cmd_abort = 1'b1;
        bus.complete  = 1'b1;
        #1;
        e = expv(P_POST, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abpost_post got=%b exp=%b", obs(), e);
        end
        tick();
        clr();
        #1;
        e = expv(P_ABORT, 1, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abpost_abort got=%b exp=%b", obs(), e);
        end
        tick();
        bus.cmd_ack = 1'b1;
        #1;
        e = expv(P_DONE, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abpost_done got=%b exp=%b", obs(), e);
        end
        tick();
        clr();
    endtask

    // Abort together with a trigger in ARMED, or a random point in FILL.
    task automatic test_abort_pre(bit in_fill);
        logic [10:0] e;
        int n, at;
        n  = $urandom_range(1, 3);
        at = $urandom_range(0, n - 1);
        bus.pretrig_count_max = 32'(n);
        bus.cmd_arm = 1'b1;
        tick();
        clr();
        tick();
        for (int w = 0; w < (in_fill ? at : n); w++) begin
            bus.sample_we = 1'b1;
            tick();
        end
        clr();
        bus.trig_hit  = 1'b1;
        bus.cmd_abort = 1'b1;
        bus.sample_we = 1'b1;
        #1;
        e = expv(in_fill ? P_FILL : P_ARMED, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abpre_hit fill=%0d got=%b exp=%b", in_fill, obs(), e);
        end
        tick();
        clr();
        #1;
        e = expv(P_ABORT, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abpre_abort fill=%0d got=%b exp=%b", in_fill, obs(), e);
        end
        tick();
        bus.cmd_ack = 1'b1;
        #1;
        e = expv(P_DONE, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abpre_done fill=%0d got=%b exp=%b", in_fill, obs(), e);
        end
        tick();
        clr();
    endtask

    task automatic test_zero_rearm();
        logic [10:0] e;
        bus.pretrig_count_max = '0;
        bus.cmd_arm = 1'b1;
        tick();
        clr();
        bus.cmd_abort = 1'b1;
        #1;
        e = expv(P_START, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL zero_start got=%b exp=%b", obs(), e);
        end
        tick();
        clr();
        bus.trig_hit = 1'b1;
        #1;
        e = expv(P_ARMED, 0, 0, 1);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL zero_armed got=%b exp=%b", obs(), e);
        end
        tick();
        clr();
        bus.complete = 1'b1;
        tick();
        clr();
        bus.cmd_arm = 1'b1;
        bus.cmd_ack = 1'b1;
        #1;
        e = expv(P_DONE, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL zero_done got=%b exp=%b", obs(), e);
        end
        tick();
        clr();
        #1;
        e = expv(P_START, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL zero_rearm got=%b exp=%b", obs(), e);
        end
        tick();
        bus.cmd_abort = 1'b1;
        tick();
        clr();
        tick();
        bus.cmd_ack = 1'b1;
        tick();
        clr();
        #1;
        e = expv(P_IDLE, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL zero_idle got=%b exp=%b", obs(), e);
        end
        tick();
    endtask

`ifdef CAPTURE_TRIG_TIMEOUT_EN
    task automatic test_timeout();
        logic [10:0] e;
        int n;
        n = $urandom_range(0, 2);
        bus.pretrig_count_max = 32'(n);
        bus.trig_timeout = 32'd10;
        bus.cmd_arm = 1'b1;
        tick();
        clr();
        tick();
        for (int w = 0; w < n; w++) begin
            bus.sample_we = 1'b1;
            tick();
        end
        clr();
        for (int k = 0; k <= 10; k++) begin
            #1;
            e = expv(P_ARMED, 0, 0, k == 10);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL tmo_armed k=%0d got=%b exp=%b", k, obs(), e);
            end
            tick();
        end
        bus.complete = 1'b1;
        #1;
        e = expv(P_POST, 0, 1, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL tmo_post got=%b exp=%b", obs(), e);
        end
        tick();
        clr();
        #1;
        e = expv(P_DONE, 0, 1, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL tmo_done got=%b exp=%b", obs(), e);
        end
        reset_n = 1'b0;
        #1;
        e = expv(P_IDLE, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL tmo_reset got=%b exp=%b", obs(), e);
        end
        bus.trig_timeout = '0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        logic [10:0] e;
        bus.pretrig_count_max = '0;
        bus.cmd_arm = 1'b1;
        tick();
        clr();
        tick();
        bus.trig_hit = 1'b1;
        tick();
        clr();
        #1;
        e = expv(P_POST, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL rstmid_post got=%b exp=%b", obs(), e);
        end
        reset_n = 1'b0;
        #1;
        e = expv(P_IDLE, 0, 0, 0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL rstmid_async got=%b exp=%b", obs(), e);
        end
        tick();
        reset_n = 1'b1;
        tick();
        #1;
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL rstmid_idle got=%b exp=%b", obs(), e);
        end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 6; i++)
            test_basic();
        test_masking();
        test_abort_post();
        test_abort_pre(1'b0);
        test_abort_pre(1'b1);
        test_zero_rearm();
`ifdef CAPTURE_TRIG_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
